// File: rtl/tc_irq_pkg.sv
// Shared definitions for the timer/counter interrupt arbiter: FSM states,
// source index map and default sizing.
package tc_irq_pkg;

    localparam int unsigned DEF_NSRC  = 6;
    localparam int unsigned DEF_VEC_W = 3;

    // Source indices; a lower index has higher fixed priority
    localparam int unsigned TC0_OCA = 0;
    localparam int unsigned TC0_OCB = 1;
    localparam int unsigned TC0_OVF = 2;
    localparam int unsigned TC1_OCA = 3;
    localparam int unsigned TC1_OCB = 4;
    localparam int unsigned TC1_OVF = 5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK,
        RELEASE
    } irq_state_e;

endpackage

// File: rtl/tc_irq_arbiter_if.sv
// Interrupt source / CPU handshake bundle. The master side is the arbiter;
// the slave side is the environment (timer sources plus CPU core).
interface tc_irq_arbiter_if
    import tc_irq_pkg::*;
#(
    parameter int unsigned NSRC  = DEF_NSRC,
    parameter int unsigned VEC_W = DEF_VEC_W
);
    logic [NSRC-1:0]  src_req;
    logic [NSRC-1:0]  src_ack;
    logic             status_reg_interrupt_enable;
    logic             interrupt_request;
    logic [VEC_W-1:0] interrupt_vector;
    logic             interrupt_executed;

    modport master (
        input  src_req,
        input  status_reg_interrupt_enable,
        input  interrupt_executed,
        output src_ack,
        output interrupt_request,
        output interrupt_vector
    );

    modport slave (
        output src_req,
        output status_reg_interrupt_enable,
        output interrupt_executed,
        input  src_ack,
        input  interrupt_request,
        input  interrupt_vector
    );
endinterface

// File: rtl/tc_irq_arbiter_rr_priority_pick.sv
// Combinational one-of-N picker. Fixed mode: lowest set index wins.
// Round-robin mode: search upward from start with wrap, first set bit wins.
module rr_priority_pick #(
    parameter int unsigned NSRC  = 6,
    parameter int unsigned VEC_W = 3,
    parameter bit          RR    = 1'b0
) (
    input  logic [NSRC-1:0]  req,
    input  logic [VEC_W-1:0] start,
    output logic             valid,
    output logic [VEC_W-1:0] winner
);

    int unsigned     base;
    int unsigned     idx;
    logic [NSRC-1:0] shifted;

    // Scan all sources from the base index, keep the first pending one
    always_comb begin
        valid   = 1'b0;
        winner  = '0;
        idx     = 0;
        shifted = '0;
        base    = RR ? 32'(start) : 32'd0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            idx = base + i;
            if (idx >= NSRC) begin
                idx = idx - NSRC;
            end
            shifted = req >> idx;
            if (!valid && shifted[0]) begin
                valid  = 1'b1;
                winner = VEC_W'(idx);
            end
        end
    end

endmodule

// File: rtl/tc_irq_arbiter.sv
// Shares the CPU interrupt request/executed handshake between the timer
// compare/overflow sources, returning a one-cycle ack to the serviced source.
module tc_irq_arbiter
    import tc_irq_pkg::*;
#(
    parameter int unsigned NSRC  = DEF_NSRC,
    parameter int unsigned VEC_W = DEF_VEC_W,
    parameter bit          RR    = 1'b0,
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    tc_irq_arbiter_if.master    bus,
    output logic [CNT_W-1:0]    irq_count
);

    irq_state_e       state_q, state_d;
    logic             req_q,   req_d;
    logic [VEC_W-1:0] vec_q,   vec_d;
    logic [NSRC-1:0]  ack_q,   ack_d;
    logic [VEC_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             pick_valid;
    logic [VEC_W-1:0] pick_idx;
    logic             grant;

    rr_priority_pick #(
        .NSRC  (NSRC),
        .VEC_W (VEC_W),
        .RR    (RR)
    ) u_pick (
        .req    (bus.src_req),
        .start  (ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // A new grant needs the CPU idle, interrupts enabled and something pending
    assign grant = (state_q == IDLE) && !bus.interrupt_executed &&
                   bus.status_reg_interrupt_enable && pick_valid;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            vec_q   <= '0;
            ack_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
            ack_q   <= ack_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: grant, wait for executed, ack, wait for executed to drop
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = REQ;
            REQ:     if (bus.interrupt_executed) state_d = ACK;
            ACK:     state_d = RELEASE;
            RELEASE: if (!bus.interrupt_executed) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; a committed grant is always acked
    always_comb begin
        req_d = req_q;
        vec_d = vec_q;
        ack_d = '0;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    req_d = 1'b1;
                    vec_d = pick_idx;
                end
            end
            REQ: begin
                if (bus.interrupt_executed) begin
                    req_d = 1'b0;
                    ack_d = NSRC'(1) << vec_q;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK: begin
                if (RR) begin
                    ptr_d = (vec_q == VEC_W'(NSRC - 1)) ? '0 : vec_q + 1'b1;
                end
            end
            RELEASE: begin
            end
            default: begin
            end
        endcase
    end

    assign bus.interrupt_request = req_q;
    assign bus.interrupt_vector  = vec_q;
    assign bus.src_ack           = ack_q;
    assign irq_count             = cnt_q;

endmodule

// File: tb/tb_tc_irq_arbiter.sv
// Scoreboard bench for tc_irq_arbiter: one fixed-priority and one
// round-robin instance, random CPU latency, expected services queued by a
// transaction-level model and checked by per-instance monitors.
module tb_tc_irq_arbiter;
    import tc_irq_pkg::*;

    localparam int unsigned NSRC  = DEF_NSRC;
    localparam int unsigned VEC_W = DEF_VEC_W;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [VEC_W-1:0] vec;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Bench-driven inputs, index 0 = fixed priority DUT, 1 = round-robin DUT
    logic [NSRC-1:0]  src_req [2];
    logic             en      [2];
    int               cpu_mode[2];   // 0 normal, 1 hold executed high, 2 never execute

    // Observed outputs
    logic [NSRC-1:0]  ack [2];
    logic             req [2];
    logic [VEC_W-1:0] vec [2];
    logic [CNT_W-1:0] cnt [2];

    exp_t        sbq   [2][$];
    int unsigned m_ptr [2];
    int unsigned m_cnt [2];

    tc_irq_arbiter_if #(.NSRC(NSRC), .VEC_W(VEC_W)) bus_f ();
    tc_irq_arbiter_if #(.NSRC(NSRC), .VEC_W(VEC_W)) bus_r ();

    tc_irq_arbiter #(.NSRC(NSRC), .VEC_W(VEC_W), .RR(1'b0), .CNT_W(CNT_W)) dut_f (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_f.master),
        .irq_count (cnt[0])
    );

    tc_irq_arbiter #(.NSRC(NSRC), .VEC_W(VEC_W), .RR(1'b1), .CNT_W(CNT_W)) dut_r (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_r.master),
        .irq_count (cnt[1])
    );

    assign bus_f.src_req                     = src_req[0];
    assign bus_r.src_req                     = src_req[1];
    assign bus_f.status_reg_interrupt_enable = en[0];
    assign bus_r.status_reg_interrupt_enable = en[1];
    assign ack[0] = bus_f.src_ack;
    assign ack[1] = bus_r.src_ack;
    assign req[0] = bus_f.interrupt_request;
    assign req[1] = bus_r.interrupt_request;
    assign vec[0] = bus_f.interrupt_vector;
    assign vec[1] = bus_r.interrupt_vector;
    assign bus_f.interrupt_executed = cpu[0].x;
    assign bus_r.interrupt_executed = cpu[1].x;

    for (genvar g = 0; g < 2; g++) begin : cpu
        logic x;

        // CPU model: take the interrupt after 0..7 cycles, drop when request drops
        initial begin
            int wait_n = 0;
            x = 1'b0;
            forever begin
                @(negedge clk);
                if (cpu_mode[g] == 1) begin
                    x = 1'b1;
                end else if (!req[g]) begin
                    x = 1'b0;
                    wait_n = $urandom_range(0, 7);
                end else if (!x && cpu_mode[g] == 0) begin
                    if (wait_n == 0) x = 1'b1;
                    else wait_n--;
                end
            end
        end

        // Monitor: protocol properties plus scoreboard pop on every ack
        initial begin
            logic             prev_req = 1'b0;
            logic             prev_ack = 1'b0;
            logic [VEC_W-1:0] prev_vec = '0;
            int               since_rise = 100;
            exp_t             e;
            logic [NSRC-1:0]  one = 1;
            forever begin
                @(posedge clk);
                #1;
                if (rst) begin
                    prev_req = 1'b0;
                    prev_ack = 1'b0;
                    since_rise = 100;
                    continue;
                end
                since_rise++;
                if (req[g] && !prev_req) begin
                    checks++;
                    if (since_rise < 4) begin
                        failures++;
                        $display("FAIL req_spacing dut=%0d actual=%0d required>=4", g, since_rise);
                    end
                    since_rise = 0;
                end
                if (req[g] && prev_req) begin
                    checks++;
                    if (vec[g] != prev_vec) begin
                        failures++;
                        $display("FAIL vec_stable dut=%0d actual=%0d required=%0d", g, vec[g], prev_vec);
                    end
                end
                if (ack[g] != '0) begin
                    checks++;
                    if (!prev_req || !x || prev_ack) begin
                        failures++;
                        $display("FAIL ack_handshake dut=%0d req_before=%0b executed=%0b prev_ack=%0b required=1,1,0",
                                 g, prev_req, x, prev_ack);
                    end
                    checks++;
                    if (sbq[g].size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_ack dut=%0d actual=%b required=none", g, ack[g]);
                    end else begin
                        e = sbq[g].pop_front();
                        checks += 2;
                        if (ack[g] != (one << e.vec)) begin
                            failures++;
                            $display("FAIL ack_onehot dut=%0d actual=%b required=%b", g, ack[g], one << e.vec);
                        end
                        if (vec[g] != e.vec) begin
                            failures++;
                            $display("FAIL ack_vector dut=%0d actual=%0d required=%0d", g, vec[g], e.vec);
                        end
                        checks++;
                        if (cnt[g] != e.cnt) begin
                            failures++;
                            $display("FAIL irq_count dut=%0d actual=%0d required=%0d", g, cnt[g], e.cnt);
                        end
                    end
                end
                prev_req = req[g];
                prev_ack = (ack[g] != '0);
                prev_vec = vec[g];
            end
        end
    end

    // Reference model: predict n services of a pending pattern
    task automatic push_services(input int d, input logic [NSRC-1:0] pat, input int n, input bit sticky);
        logic [NSRC-1:0] p;
        logic [NSRC-1:0] one;
        p   = pat;
        one = 1;
        for (int s = 0; s < n; s++) begin
            int unsigned start;
            int unsigned win;
            start = (d == 1) ? m_ptr[d] : 0;
            win = 0;
            for (int unsigned k = 0; k < NSRC; k++) begin
                int unsigned i;
                i = (start + k) % NSRC;
                if (((p >> i) & 1) != 0) begin
                    win = i;
                    break;
                end
            end
            if (!sticky) p = p & ~(one << win);
            m_ptr[d] = (win + 1) % NSRC;
            m_cnt[d] = (m_cnt[d] + 1) % (1 << CNT_W);
            sbq[d].push_back('{vec: VEC_W'(win), cnt: CNT_W'(m_cnt[d])});
        end
    endtask

    // Source model: serviced sources drop their bit on ack unless sticky
    task automatic drain(input int d, input int n, input bit sticky);
        int left;
        int budget;
        left = n;
        budget = 40 * n + 50;
        while (left > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (ack[d] != '0) begin
                left--;
                if (!sticky) src_req[d] = src_req[d] & ~ack[d];
                else if (left == 0) src_req[d] = '0;
            end
        end
        if (left > 0) begin
            checks++;
            failures++;
            $display("FAIL service_timeout dut=%0d missing=%0d required=0", d, left);
            sbq[d].delete();
            src_req[d] = '0;
        end
    endtask

    task automatic run_round(input int d, input logic [NSRC-1:0] pat, input int sticky_n);
        int n;
        n = (sticky_n > 0) ? sticky_n : $countones(pat);
        push_services(d, pat, n, sticky_n > 0);
        src_req[d] = pat;
        drain(d, n, sticky_n > 0);
    endtask

    task automatic check_eq(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst = 1'b1;
        src_req[0] = 6'b000001;
        src_req[1] = '0;
        en[0] = 1'b1;
        en[1] = 1'b1;
        cpu_mode[0] = 1;
        cpu_mode[1] = 0;
        m_ptr[0] = 0; m_ptr[1] = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;

        // Reset values, executed held high out of reset
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("reset_req", int'(req[d]), 0);
            check_eq("reset_ack", int'(ack[d]), 0);
            check_eq("reset_vec", int'(vec[d]), 0);
            check_eq("reset_cnt", int'(cnt[d]), 0);
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check_eq("no_req_while_executed", int'(req[0]), 0);
        end
        cpu_mode[0] = 0;
        run_round(0, 6'b000001, 0);

        // Fixed priority with sources clearing on ack: 2, 3, 5
        run_round(0, 6'b101100, 0);

        // Round-robin with all sources held: 0..5 then 0
        run_round(1, 6'b111111, 7);

        // Global enable gates new grants only
        en[0] = 1'b0;
        src_req[0] = 6'b000100;
        repeat (100) begin
            @(negedge clk);
            check_eq("no_req_while_disabled", int'(req[0]), 0);
        end
        cpu_mode[0] = 2;
        en[0] = 1'b1;
        @(negedge clk);
        check_eq("enable_latency_req", int'(req[0]), 1);
        check_eq("enable_latency_vec", int'(vec[0]), 2);
        en[0] = 1'b0;
        push_services(0, 6'b000100, 1, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check_eq("req_held_after_disable", int'(req[0]), 1);
        end
        cpu_mode[0] = 0;
        drain(0, 1, 1'b0);
        en[0] = 1'b1;

        // Random patterns with random CPU latency on both instances
        for (int d = 0; d < 2; d++) begin
            int served;
            logic [NSRC-1:0] pat;
            served = 0;
            while (served < 300) begin
                pat = NSRC'($urandom_range(1, (1 << NSRC) - 1));
                run_round(d, pat, 0);
                served += $countones(pat);
            end
        end

        // Asynchronous reset while a request is outstanding
        cpu_mode[0] = 2;
        src_req[0] = 6'b000010;
        b = 0;
        while (!req[0] && b < 20) begin
            @(negedge clk);
            b++;
        end
        check_eq("req_before_async_reset", int'(req[0]), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_reset_req", int'(req[0]), 0);
        check_eq("async_reset_ack", int'(ack[0]), 0);
        check_eq("async_reset_cnt", int'(cnt[0]), 0);
        check_eq("async_reset_cnt_rr", int'(cnt[1]), 0);
        m_ptr[0] = 0; m_ptr[1] = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        @(negedge clk);
        rst = 1'b0;
        cpu_mode[0] = 0;
        run_round(0, 6'b000010, 0);

        repeat (5) @(negedge clk);
        check_eq("scoreboard_empty_fixed", sbq[0].size(), 0);
        check_eq("scoreboard_empty_rr", sbq[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tc_irq_arbiter.md
Name: tc_irq_arbiter

Overview:
- Shares the single CPU interrupt handshake (interrupt_request / interrupt_executed) between the interrupt sources of both timer/counter instances: compare A, compare B and overflow for timer 0 and timer 1.
- Picks one pending source by fixed or round-robin priority and presents its vector to the CPU.
- Runs the four-phase request/executed handshake, then returns a one-cycle acknowledge to the serviced source so that source clears its TIFR flag.
- Sits between the timer/counters (each source level = TIFR bit AND TIMSK bit) and the CPU core.

Parameters:
- NSRC, 6, number of interrupt sources (index 0 = highest fixed priority).
- VEC_W, 3, vector width; must satisfy 2**VEC_W >= NSRC.
- RR, 0, 0 = fixed priority (lowest index wins); 1 = round-robin starting from rr_ptr.
- CNT_W, 8, width of the serviced-interrupt counter.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- src_req  in  NSRC  level pending request per source.
- src_ack  out  NSRC  one-hot, one-cycle acknowledge to the serviced source.
- status_reg_interrupt_enable  in  1  global interrupt enable (I bit); gates new grants only.
- interrupt_request  out  1  registered request to the CPU.
- interrupt_vector  out  VEC_W  index of the granted source; stable while interrupt_request is high.
- interrupt_executed  in  1  CPU level handshake: high = interrupt taken; held until request drops.
- irq_count  out  CNT_W  number of serviced interrupts, wrapping.

Behaviour:
- Reset (async, any state): state = IDLE; interrupt_request = 0; src_ack = 0; interrupt_vector = 0; rr_ptr = 0; irq_count = 0.
- FSM states: IDLE, REQ, ACK, RELEASE. All outputs are registered.
- IDLE:
  - Grant at a posedge when interrupt_executed == 0, status_reg_interrupt_enable == 1 and src_req != 0.
  - On grant: latch the winner into interrupt_vector, set interrupt_request = 1, go to REQ.
  - The request is visible one cycle after src_req is sampled.
  - If interrupt_executed is high (for example, still high after reset), stay in IDLE; this avoids a false handshake.
- REQ:
  - Hold interrupt_request = 1 and interrupt_vector until interrupt_executed is sampled high.
  - On that edge: interrupt_request = 0; src_ack[vector] = 1 for exactly one cycle; irq_count += 1 (wraps to 0); go to ACK.
  - A grant is committed. Neither status_reg_interrupt_enable falling nor src_req[vector] falling withdraws it; the ack is still issued.
- ACK: src_ack returns to 0; go to RELEASE. In RR mode, rr_ptr = (vector + 1) mod NSRC.
- RELEASE:
  - Wait for interrupt_executed == 0, then go to IDLE.
  - Earliest next request is 2 cycles after the ack cycle; minimum back-to-back spacing is 4 cycles.
- Fixed priority: lowest set index wins.
- Round-robin: search upward from rr_ptr with wrap; the first set bit wins.
- Simultaneous requests: exactly one winner per grant; losers stay pending (level) and are re-evaluated in IDLE.
- src_req bits at or above NSRC do not exist. interrupt_vector bits above the winner index are zero.
- Latency: from src_req rising in IDLE (conditions met) to interrupt_request high is 1 cycle. From interrupt_executed sampled high to interrupt_request low plus src_ack pulse is 1 cycle.

Decomposition:
- Package tc_irq_pkg:
  - FSM state enum (IDLE, REQ, ACK, RELEASE).
  - Source index constants: TC0_OCA = 0, TC0_OCB = 1, TC0_OVF = 2, TC1_OCA = 3, TC1_OCB = 4, TC1_OVF = 5.
  - Default NSRC and VEC_W.
- Sub-module rr_priority_pick:
  - Combinational.
  - Inputs: req vector, start pointer, RR parameter.
  - Outputs: valid, winner index.
  - Shared later by the bus arbiter.

Test Plan:
- Reset with interrupt_executed = 1 and src_req = 6'b000001 → no interrupt_request until executed falls. Then request is high 1 cycle later with vector = 0; executed high → src_ack = 6'b000001 for one cycle; irq_count = 1.
- Fixed priority, src_req = 6'b101100 held, CPU acks each grant and the acked source drops its bit → vectors 2, 3, 5 in order; irq_count = 3; each src_ack is a single-cycle pulse.
- RR = 1, src_req = 6'b111111 held constant → vectors 0, 1, 2, 3, 4, 5, 0 over 7 services; back-to-back spacing of at least 4 cycles.
- status_reg_interrupt_enable = 0 with src_req = 6'b000100 → no request for 100 cycles. Enable = 1 → request after 1 cycle. Drop enable during REQ → request held and acked normally.
- CPU delays interrupt_executed by random 0–7 cycles over 300 interrupts → interrupt_vector never changes while request is high, no ack without executed, irq_count wraps from 255 to 0.
- Assert rst during REQ → interrupt_request = 0 and src_ack = 0 immediately (asynchronous). After release, a pending source is re-granted with vector intact and irq_count = 0.
